// File: rtl/base_ram_sched.sv
// Shares the BaseRAM port between IFU (read-only) and LSU; alternates grants on ties.
// Latency WAIT_CYCLES+1 cycles grant-to-resp; requests are level-held until resp, one access in flight.
module base_ram_sched #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_resp_o,

    input  logic        lsu_req_i,
    input  logic        lsu_we_n_i,
    input  logic [3:0]  lsu_be_n_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_o,

    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        ram_data_oe,
    output logic [19:0] ram_addr_o,
    output logic [3:0]  ram_be_n_o,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_lsu_q, owner_lsu_d;
    logic        last_lsu_q, last_lsu_d;
    logic        we_n_q, we_n_d;
    logic [3:0]  be_n_q, be_n_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;

    logic gnt_lsu, gnt_ifu;

    // Address bits outside the 4 MB word window are fixed by upstream decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ifu_addr_i[31:22], ifu_addr_i[1:0],
                                lsu_addr_i[31:22], lsu_addr_i[1:0]};

    // On a tie the requester not served last wins; last_lsu_q=0 out of reset favours the LSU.
    assign gnt_lsu = lsu_req_i & (~ifu_req_i | ~last_lsu_q);
    assign gnt_ifu = ifu_req_i & ~gnt_lsu;

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        last_lsu_d  = last_lsu_q;
        we_n_d      = we_n_q;
        be_n_d      = be_n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_lsu) begin
                    state_d     = ACCESS;
                    owner_lsu_d = 1'b1;
                    last_lsu_d  = 1'b1;
                    we_n_d      = lsu_we_n_i;
                    be_n_d      = lsu_be_n_i;
                    addr_d      = lsu_addr_i[21:2];
                    wdata_d     = lsu_wdata_i;
                    cnt_d       = CNT_INIT;
                end else if (gnt_ifu) begin
                    state_d     = ACCESS;
                    owner_lsu_d = 1'b0;
                    last_lsu_d  = 1'b0;
                    we_n_d      = 1'b1;
                    be_n_d      = 4'h0;
                    addr_d      = ifu_addr_i[21:2];
                    wdata_d     = lsu_wdata_i;
                    cnt_d       = CNT_INIT;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (we_n_q) begin
                        if (owner_lsu_q) lsu_rdata_d = ram_data_i;
                        else             ifu_rdata_d = ram_data_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'hF;
            addr_q      <= 20'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= 4'h0;
            ifu_rdata_q <= 32'h0;
            lsu_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            last_lsu_q  <= last_lsu_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    // Pins decode from registered state only, so reset idles the bus without waiting for an edge.
    logic in_access;
    assign in_access = (state_q == ACCESS);

    assign ram_ce_n_o  = ~in_access;
    assign ram_oe_n_o  = ~(in_access & we_n_q);
    // we_n releases one cycle before the phase ends so addr/data hold across its rising edge.
    assign ram_we_n_o  = ~(in_access & ~we_n_q & (cnt_q != 4'd0));
    assign ram_data_oe = in_access & ~we_n_q;
    assign ram_be_n_o  = in_access ? be_n_q : 4'hF;
    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;

    assign ifu_resp_o  = (state_q == RESP) & ~owner_lsu_q;
    assign lsu_resp_o  = (state_q == RESP) &  owner_lsu_q;
    assign ifu_rdata_o = ifu_rdata_q;
    assign lsu_rdata_o = lsu_rdata_q;

endmodule

// File: tb/tb_base_ram_sched.sv
// Directed bench for base_ram_sched: default instance plus a WAIT_CYCLES=5 instance.
module tb_base_ram_sched;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic [31:0] ifu_rdata;
    logic        ifu_resp;
    logic        lsu_req;
    logic        lsu_we_n;
    logic [3:0]  lsu_be_n;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_resp;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_doe;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    logic        ifu5_req;
    logic [31:0] ifu5_addr;
    logic [31:0] ifu5_rdata;
    logic        ifu5_resp;
    logic        lsu5_req;
    logic        lsu5_we_n;
    logic [3:0]  lsu5_be_n;
    logic [31:0] lsu5_addr;
    logic [31:0] lsu5_wdata;
    logic [31:0] lsu5_rdata;
    logic        lsu5_resp;
    logic [31:0] ram5_dout;
    logic        ram5_doe;
    logic [19:0] ram5_addr;
    logic [3:0]  ram5_be_n;
    logic        ram5_ce_n;
    logic        ram5_oe_n;
    logic        ram5_we_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    base_ram_sched dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_rdata_o(ifu_rdata), .ifu_resp_o(ifu_resp),
        .lsu_req_i(lsu_req), .lsu_we_n_i(lsu_we_n), .lsu_be_n_i(lsu_be_n), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_rdata_o(lsu_rdata), .lsu_resp_o(lsu_resp),
        .ram_data_i(ram_din), .ram_data_o(ram_dout), .ram_data_oe(ram_doe), .ram_addr_o(ram_addr),
        .ram_be_n_o(ram_be_n), .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n)
    );

    base_ram_sched #(.WAIT_CYCLES(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_i(ifu5_req), .ifu_addr_i(ifu5_addr), .ifu_rdata_o(ifu5_rdata), .ifu_resp_o(ifu5_resp),
        .lsu_req_i(lsu5_req), .lsu_we_n_i(lsu5_we_n), .lsu_be_n_i(lsu5_be_n), .lsu_addr_i(lsu5_addr),
        .lsu_wdata_i(lsu5_wdata), .lsu_rdata_o(lsu5_rdata), .lsu_resp_o(lsu5_resp),
        .ram_data_i(ram_din), .ram_data_o(ram5_dout), .ram_data_oe(ram5_doe), .ram_addr_o(ram5_addr),
        .ram_be_n_o(ram5_be_n), .ram_ce_n_o(ram5_ce_n), .ram_oe_n_o(ram5_oe_n), .ram_we_n_o(ram5_we_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ifu_req   = 1'b0; ifu_addr  = 32'h8000_0000;
        lsu_req   = 1'b0; lsu_we_n  = 1'b1; lsu_be_n = 4'hF;
        lsu_addr  = 32'h8000_0000; lsu_wdata = 32'h0;
        ram_din   = 32'h0;
        ifu5_req  = 1'b0; ifu5_addr = 32'h8000_0000;
        lsu5_req  = 1'b0; lsu5_we_n = 1'b1; lsu5_be_n = 4'hF;
        lsu5_addr = 32'h8000_0000; lsu5_wdata = 32'h0;

        // Reset values
        step(); step();
        chk("rst_ce_n",  32'(ram_ce_n),  32'h1);
        chk("rst_oe_n",  32'(ram_oe_n),  32'h1);
        chk("rst_we_n",  32'(ram_we_n),  32'h1);
        chk("rst_be_n",  32'(ram_be_n),  32'hF);
        chk("rst_doe",   32'(ram_doe),   32'h0);
        chk("rst_addr",  32'(ram_addr),  32'h0);
        chk("rst_dout",  ram_dout,       32'h0);
        chk("rst_iresp", 32'(ifu_resp),  32'h0);
        chk("rst_lresp", 32'(lsu_resp),  32'h0);
        chk("rst_irdat", ifu_rdata,      32'h0);
        chk("rst_lrdat", lsu_rdata,      32'h0);
        rst_n = 1'b1;
        step();
        chk("idle_ce_n", 32'(ram_ce_n), 32'h1);

        // IFU read, WAIT_CYCLES=2
        ifu_req = 1'b1; ifu_addr = 32'h8000_0010; ram_din = 32'h1234_5678;
        step();
        chk("t1_ce_n0",  32'(ram_ce_n), 32'h0);
        chk("t1_oe_n0",  32'(ram_oe_n), 32'h0);
        chk("t1_addr",   32'(ram_addr), 32'h4);
        chk("t1_be_n",   32'(ram_be_n), 32'h0);
        chk("t1_doe",    32'(ram_doe),  32'h0);
        chk("t1_resp0",  32'(ifu_resp), 32'h0);
        step();
        chk("t1_ce_n1",  32'(ram_ce_n), 32'h0);
        chk("t1_oe_n1",  32'(ram_oe_n), 32'h0);
        chk("t1_resp1",  32'(ifu_resp), 32'h0);
        step();
        chk("t1_resp",   32'(ifu_resp), 32'h1);
        chk("t1_rdata",  ifu_rdata,     32'h1234_5678);
        chk("t1_ce_nr",  32'(ram_ce_n), 32'h1);
        chk("t1_lresp",  32'(lsu_resp), 32'h0);
        ifu_req = 1'b0;
        step();
        chk("t1_resp_end", 32'(ifu_resp), 32'h0);

        // LSU write
        lsu_req = 1'b1; lsu_we_n = 1'b0; lsu_be_n = 4'b1100;
        lsu_addr = 32'h8000_0020; lsu_wdata = 32'hA5A5_0F0F;
        step();
        chk("t2_doe0",  32'(ram_doe),  32'h1);
        chk("t2_we_n0", 32'(ram_we_n), 32'h0);
        chk("t2_oe_n0", 32'(ram_oe_n), 32'h1);
        chk("t2_ce_n0", 32'(ram_ce_n), 32'h0);
        chk("t2_be_n",  32'(ram_be_n), 32'hC);
        chk("t2_addr",  32'(ram_addr), 32'h8);
        chk("t2_dout",  ram_dout,      32'hA5A5_0F0F);
        step();
        chk("t2_doe1",  32'(ram_doe),  32'h1);
        chk("t2_we_n1", 32'(ram_we_n), 32'h1);
        chk("t2_ce_n1", 32'(ram_ce_n), 32'h0);
        chk("t2_dout1", ram_dout,      32'hA5A5_0F0F);
        step();
        chk("t2_lresp", 32'(lsu_resp), 32'h1);
        chk("t2_iresp", 32'(ifu_resp), 32'h0);
        chk("t2_doer",  32'(ram_doe),  32'h0);
        chk("t2_lrdat", lsu_rdata,     32'h0);
        chk("t2_irdat", ifu_rdata,     32'h1234_5678);
        lsu_req = 1'b0; lsu_we_n = 1'b1;
        step();
        chk("t2_lresp_end", 32'(lsu_resp), 32'h0);

        // Both requesters held from reset: LSU, IFU, LSU, IFU, resp every 4 cycles
        rst_n = 1'b0;
        step();
        lsu_req = 1'b1; lsu_addr = 32'h8000_0040;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0080;
        ram_din = 32'hCAFE_F00D;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("t3_resp_c%0d", i), {30'h0, lsu_resp, ifu_resp},
                {30'h0, (i == 2 || i == 10), (i == 6 || i == 14)});
            if (i == 0) chk("t3_addr_lsu", 32'(ram_addr), 32'h10);
            if (i == 4) chk("t3_addr_ifu", 32'(ram_addr), 32'h20);
        end
        lsu_req = 1'b0; ifu_req = 1'b0;
        chk("t3_lrdat", lsu_rdata, 32'hCAFE_F00D);
        step();
        chk("t3_idle", 32'(ram_ce_n), 32'h1);

        // Reset during ACCESS of an LSU write
        lsu_req = 1'b1; lsu_we_n = 1'b0; lsu_be_n = 4'h0;
        lsu_addr = 32'h8000_0100; lsu_wdata = 32'h1122_3344;
        step();
        chk("t4_doe_pre",  32'(ram_doe),  32'h1);
        chk("t4_we_n_pre", 32'(ram_we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_ce_n",  32'(ram_ce_n), 32'h1);
        chk("t4_we_n",  32'(ram_we_n), 32'h1);
        chk("t4_doe",   32'(ram_doe),  32'h0);
        chk("t4_be_n",  32'(ram_be_n), 32'hF);
        lsu_req = 1'b0; lsu_we_n = 1'b1;
        step();
        chk("t4_lresp_r0", 32'(lsu_resp), 32'h0);
        step();
        chk("t4_lresp_r1", 32'(lsu_resp), 32'h0);
        rst_n = 1'b1;
        step();
        chk("t4_idle_ce",  32'(ram_ce_n), 32'h1);
        chk("t4_lresp_a0", 32'(lsu_resp), 32'h0);
        step();
        chk("t4_lresp_a1", 32'(lsu_resp), 32'h0);

        // LSU read whose req drops one cycle after grant
        lsu_req = 1'b1; lsu_we_n = 1'b1; lsu_be_n = 4'h0;
        lsu_addr = 32'h8000_0200; ram_din = 32'hDEAD_BEEF;
        step();
        chk("t6_oe_n",  32'(ram_oe_n), 32'h0);
        chk("t6_addr",  32'(ram_addr), 32'h80);
        lsu_req = 1'b0;
        step();
        chk("t6_ce_n1", 32'(ram_ce_n), 32'h0);
        step();
        chk("t6_lresp", 32'(lsu_resp), 32'h1);
        chk("t6_lrdat", lsu_rdata,     32'hDEAD_BEEF);
        step();
        chk("t6_lresp_end", 32'(lsu_resp), 32'h0);
        chk("t6_ce_n_end",  32'(ram_ce_n), 32'h1);
        step();
        chk("t6_no_regrant", 32'(ram_ce_n), 32'h1);

        // WAIT_CYCLES=5 LSU read: data sampled on the last oe_n-low cycle only
        lsu5_req = 1'b1; lsu5_we_n = 1'b1; lsu5_be_n = 4'h0;
        lsu5_addr = 32'h8000_0300; ram_din = 32'h0BAD_F00D;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t5_oe_n_c%0d", c), 32'(ram5_oe_n), 32'h0);
            chk($sformatf("t5_resp_c%0d", c), 32'(lsu5_resp), 32'h0);
            if (c == 4) ram_din = 32'h600D_CAFE;
            else        step();
        end
        step();
        chk("t5_lresp", 32'(lsu5_resp), 32'h1);
        chk("t5_lrdat", lsu5_rdata,     32'h600D_CAFE);
        chk("t5_oe_nr", 32'(ram5_oe_n), 32'h1);
        chk("t5_iresp", 32'(ifu5_resp), 32'h0);
        lsu5_req = 1'b0;
        step();
        chk("t5_lresp_end", 32'(lsu5_resp), 32'h0);
        chk("t5_main_hold", lsu_rdata,      32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
